// File: rtl/alu_pipe_pkg.sv
// Shared constants for the ALU result pipeline: default widths and the bit
// layout of the packed {result, branch, carry} payload carried by each stage.
package alu_pipe_pkg;

    localparam int unsigned ALU_DATA_W         = 32;
    localparam int unsigned ALU_PIPE_MAX_DEPTH = 8;

    // Packed payload layout: carry in bit 0, branch in bit 1, result above them.
    localparam int unsigned CARRY_BIT  = 0;
    localparam int unsigned BRANCH_BIT = 1;
    localparam int unsigned RESULT_LSB = 2;

    // Total packed payload width for a given result width.
    function automatic int unsigned payload_width(input int unsigned data_w);
        return data_w + RESULT_LSB;
    endfunction

endpackage

// File: rtl/alu_pipe_stage.sv
// One elastic pipeline stage: a valid bit plus a packed payload register.
// Loads from its upstream neighbour when load_i is high; flush drops the entry.
module alu_pipe_stage
    import alu_pipe_pkg::*;
#(
    parameter int unsigned PAYLOAD_W  = payload_width(ALU_DATA_W),
    parameter bit          CLEAR_DATA = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 async_reset_i,
    input  logic                 flush_i,
    input  logic                 load_i,
    input  logic                 valid_i,
    input  logic [PAYLOAD_W-1:0] payload_i,
    output logic                 valid_o,
    output logic [PAYLOAD_W-1:0] payload_o
);

    logic                 valid_q, valid_d;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;

    // Next state: flush wins; otherwise load when the downstream chain allows it.
    always_comb begin
        valid_d   = valid_q;
        payload_d = payload_q;
        if (flush_i) begin
            valid_d = 1'b0;
            if (CLEAR_DATA) begin
                payload_d = '0;
            end
        end else if (load_i) begin
            valid_d = valid_i;
            if (valid_i) begin
                payload_d = payload_i;
            end else if (CLEAR_DATA) begin
                // Drained without refill: stage goes empty.
                payload_d = '0;
            end
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge async_reset_i) begin
        if (!async_reset_i) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
        end
    end

    assign valid_o   = valid_q;
    assign payload_o = payload_q;

endmodule

// File: rtl/alu_result_pipe.sv
// Elastic DEPTH-stage pipeline for ALU carry/result/branch with valid/ready
// handshake, bubble collapsing, synchronous flush and a registered occupancy.
module alu_result_pipe
    import alu_pipe_pkg::*;
#(
    parameter int unsigned DATA_W     = ALU_DATA_W,
    parameter int unsigned DEPTH      = 2,
    parameter bit          CLEAR_DATA = 1'b0
) (
    input  logic                       clk_i,
    input  logic                       async_reset_i,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic                       in_carry_i,
    input  logic [DATA_W-1:0]          in_result_i,
    input  logic                       in_branch_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic                       out_carry_o,
    output logic [DATA_W-1:0]          out_result_o,
    output logic                       out_branch_o,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

    localparam int unsigned PAYLOAD_W = payload_width(DATA_W);
    localparam int unsigned OCC_W     = $clog2(DEPTH + 1);

    logic [DEPTH:0]         rdy;
    logic [DEPTH-1:0]       valid;
    logic [PAYLOAD_W-1:0]   payload [DEPTH];
    logic [PAYLOAD_W-1:0]   in_payload;
    logic                   in_xfer;
    logic                   out_xfer;
    logic [OCC_W-1:0]       occ_q, occ_d;

    // Pack the ALU outputs into the shared payload layout.
    always_comb begin
        in_payload                         = '0;
        in_payload[CARRY_BIT]              = in_carry_i;
        in_payload[BRANCH_BIT]             = in_branch_i;
        in_payload[RESULT_LSB +: DATA_W]   = in_result_i;
    end

    // Ready chain: a stage accepts if it is empty or everything below it moves.
    // Accumulated in a local so the vector never feeds back on itself.
    always_comb begin
        logic chain;
        chain      = out_ready_i;
        rdy        = '0;
        rdy[DEPTH] = chain;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            chain  = chain || !valid[k];
            rdy[k] = chain;
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic                 src_valid;
        logic [PAYLOAD_W-1:0] src_payload;

        if (k == 0) begin : g_head
            assign src_valid   = in_valid_i;
            assign src_payload = in_payload;
        end else begin : g_body
            assign src_valid   = valid[k-1];
            assign src_payload = payload[k-1];
        end

        alu_pipe_stage #(
            .PAYLOAD_W  (PAYLOAD_W),
            .CLEAR_DATA (CLEAR_DATA)
        ) u_stage (
            .clk_i         (clk_i),
            .async_reset_i (async_reset_i),
            .flush_i       (flush_i),
            .load_i        (rdy[k]),
            .valid_i       (src_valid),
            .payload_i     (src_payload),
            .valid_o       (valid[k]),
            .payload_o     (payload[k])
        );
    end

    // Flush discards the input beat, so upstream is never stalled by it.
    assign in_ready_o = rdy[0] || flush_i;
    assign in_xfer    = in_valid_i && rdy[0];
    assign out_xfer   = valid[DEPTH-1] && out_ready_i;

    // Occupancy next state: flush clears, otherwise count transfers in and out.
    always_comb begin
        occ_d = occ_q;
        if (flush_i) begin
            occ_d = '0;
        end else if (in_xfer && !out_xfer) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (out_xfer && !in_xfer) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    // Occupancy register.
    always_ff @(posedge clk_i or negedge async_reset_i) begin
        if (!async_reset_i) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy_o  = occ_q;
    assign out_valid_o  = valid[DEPTH-1];
    assign out_carry_o  = payload[DEPTH-1][CARRY_BIT];
    assign out_branch_o = payload[DEPTH-1][BRANCH_BIT];
    assign out_result_o = payload[DEPTH-1][RESULT_LSB +: DATA_W];

endmodule

// File: tb/tb_alu_result_pipe.sv
// Directed bench for alu_result_pipe: a DEPTH=2/CLEAR_DATA=0 instance checked
// against a FIFO scoreboard, and a DEPTH=4/CLEAR_DATA=1 instance for bubble
// collapse and payload clearing on flush.
module tb_alu_result_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    // DEPTH=2, CLEAR_DATA=0 instance
    logic        flush, in_valid, in_carry, in_branch, out_ready;
    logic [31:0] in_result;
    logic        in_ready, out_valid, out_carry, out_branch;
    logic [31:0] out_result;
    logic [1:0]  occupancy;

    // DEPTH=4, CLEAR_DATA=1 instance
    logic        d4_flush, d4_in_valid, d4_in_carry, d4_in_branch, d4_out_ready;
    logic [31:0] d4_in_result;
    logic        d4_in_ready, d4_out_valid, d4_out_carry, d4_out_branch;
    logic [31:0] d4_out_result;
    logic [2:0]  d4_occ;

    alu_result_pipe #(
        .DATA_W     (32),
        .DEPTH      (2),
        .CLEAR_DATA (1'b0)
    ) u_dut (
        .clk_i         (clk),
        .async_reset_i (rst_n),
        .flush_i       (flush),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .in_carry_i    (in_carry),
        .in_result_i   (in_result),
        .in_branch_i   (in_branch),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_carry_o   (out_carry),
        .out_result_o  (out_result),
        .out_branch_o  (out_branch),
        .occupancy_o   (occupancy)
    );

    alu_result_pipe #(
        .DATA_W     (32),
        .DEPTH      (4),
        .CLEAR_DATA (1'b1)
    ) u_dut4 (
        .clk_i         (clk),
        .async_reset_i (rst_n),
        .flush_i       (d4_flush),
        .in_valid_i    (d4_in_valid),
        .in_ready_o    (d4_in_ready),
        .in_carry_i    (d4_in_carry),
        .in_result_i   (d4_in_result),
        .in_branch_i   (d4_in_branch),
        .out_valid_o   (d4_out_valid),
        .out_ready_i   (d4_out_ready),
        .out_carry_o   (d4_out_carry),
        .out_result_o  (d4_out_result),
        .out_branch_o  (d4_out_branch),
        .occupancy_o   (d4_occ)
    );

    int errors = 0;
    int checks = 0;

    // Scoreboard entry: {carry, branch, result}
    typedef logic [33:0] entry_t;
    entry_t sb[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] r, input logic c, input logic b);
        in_valid  = v;
        in_result = r;
        in_carry  = c;
        in_branch = b;
    endtask

    // Advance one clock on the main instance, scoring transfers seen just before the edge.
    task automatic tick();
        logic   in_x, out_x;
        entry_t exp_e;
        #1;
        in_x  = in_valid && in_ready && !flush;
        out_x = out_valid && out_ready;
        if (out_x) begin
            if (sb.size() == 0) begin
                check("out_valid_unexpected", out_valid, 1'b0);
            end else begin
                exp_e = sb.pop_front();
                check("out_entry", {out_carry, out_branch, out_result}, exp_e);
            end
        end
        if (flush) sb.delete();
        if (in_x) sb.push_back({in_carry, in_branch, in_result});
        @(posedge clk);
        #1;
        check("occupancy", occupancy, sb.size());
    endtask

    initial begin
        rst_n        = 1'b0;
        flush        = 1'b0;
        out_ready    = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        d4_flush     = 1'b0;
        d4_in_valid  = 1'b0;
        d4_in_carry  = 1'b0;
        d4_in_branch = 1'b0;
        d4_in_result = 32'h0;
        d4_out_ready = 1'b0;

        // Reset defaults
        #12;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_occ", occupancy, 2'd0);
        check("rst_out_result", out_result, 32'h0);
        check("rst_d4_out_valid", d4_out_valid, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", in_ready, 1'b1);

        // Streaming: latency 2, one per cycle, occupancy steady at 2
        out_ready = 1'b1;
        drive(1'b1, 32'h1, 1'b1, 1'b0);
        tick();
        check("lat_edge1_out_valid", out_valid, 1'b0);
        drive(1'b1, 32'h2, 1'b0, 1'b1);
        tick();
        check("lat_edge2_out_valid", out_valid, 1'b1);
        check("lat_edge2_result", out_result, 32'h1);
        drive(1'b1, 32'h3, 1'b1, 1'b0);
        tick();
        check("stream_occ", occupancy, 2'd2);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (3) tick();

        // Back-pressure: fill, stall stability, drain
        out_ready = 1'b0;
        drive(1'b1, 32'hA, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'hB, 1'b1, 1'b1);
        tick();
        check("bp_full_in_ready", in_ready, 1'b0);
        drive(1'b1, 32'hC, 1'b0, 1'b0);
        tick();
        check("bp_hold_valid", out_valid, 1'b1);
        check("bp_hold_result", out_result, 32'hA);
        tick();
        check("bp_hold_result2", out_result, 32'hA);
        check("bp_hold_occ", occupancy, 2'd2);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        out_ready = 1'b1;
        tick();
        check("bp_drain_occ1", occupancy, 2'd1);
        tick();
        check("bp_drain_occ0", occupancy, 2'd0);

        // Full with simultaneous in/out for 10 cycles
        out_ready = 1'b0;
        drive(1'b1, 32'h100, 1'b1, 1'b1);
        tick();
        drive(1'b1, 32'h101, 1'b0, 1'b0);
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h200 + 32'(i), i[0], (i % 3) == 0);
            tick();
            check("full_simul_occ", occupancy, 2'd2);
            check("full_simul_in_ready", in_ready, 1'b1);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (3) tick();

        // Flush while full and stalled; 0x55 must never appear
        out_ready = 1'b0;
        drive(1'b1, 32'h300, 1'b0, 1'b1);
        tick();
        drive(1'b1, 32'h301, 1'b1, 1'b0);
        tick();
        flush = 1'b1;
        drive(1'b1, 32'h55, 1'b1, 1'b1);
        #1;
        check("flush_in_ready", in_ready, 1'b1);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_occ", occupancy, 2'd0);
        out_ready = 1'b1;
        repeat (4) tick();

        // Flush with a same-cycle output beat: that beat is consumed, not repeated
        out_ready = 1'b0;
        drive(1'b1, 32'h310, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h311, 1'b1, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        out_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_out_beat_valid", out_valid, 1'b0);
        repeat (3) tick();

        // Reset asserted mid-stream while full
        out_ready = 1'b0;
        drive(1'b1, 32'h400, 1'b1, 1'b1);
        tick();
        drive(1'b1, 32'h401, 1'b1, 1'b1);
        tick();
        check("pre_rst_occ", occupancy, 2'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_result", out_result, 32'h0);
        check("midrst_out_carry", out_carry, 1'b0);
        check("midrst_out_branch", out_branch, 1'b0);
        check("midrst_occ", occupancy, 2'd0);
        sb.delete();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        drive(1'b1, 32'h777, 1'b1, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (3) tick();

        // DEPTH=4: single entry collapses through bubbles to the output stage
        d4_out_ready = 1'b0;
        d4_in_valid  = 1'b1;
        d4_in_result = 32'hDEAD;
        d4_in_carry  = 1'b1;
        d4_in_branch = 1'b0;
        tick();
        d4_in_valid = 1'b0;
        check("d4_bubble_occ", d4_occ, 3'd1);
        check("d4_bubble_in_ready", d4_in_ready, 1'b1);
        check("d4_edge1_out_valid", d4_out_valid, 1'b0);
        tick();
        tick();
        check("d4_edge3_out_valid", d4_out_valid, 1'b0);
        tick();
        check("d4_edge4_out_valid", d4_out_valid, 1'b1);
        check("d4_edge4_result", d4_out_result, 32'hDEAD);
        check("d4_edge4_carry", d4_out_carry, 1'b1);
        check("d4_edge4_in_ready", d4_in_ready, 1'b1);
        check("d4_edge4_occ", d4_occ, 3'd1);
        tick();
        check("d4_stall_result", d4_out_result, 32'hDEAD);

        // DEPTH=4, CLEAR_DATA=1: flush zeroes the output payload
        d4_in_valid  = 1'b1;
        d4_in_result = 32'h77;
        tick();
        check("d4_two_occ", d4_occ, 3'd2);
        d4_flush     = 1'b1;
        d4_in_result = 32'h55;
        d4_in_carry  = 1'b1;
        d4_in_branch = 1'b1;
        #1;
        check("d4_flush_in_ready", d4_in_ready, 1'b1);
        tick();
        d4_flush    = 1'b0;
        d4_in_valid = 1'b0;
        check("d4_flush_out_valid", d4_out_valid, 1'b0);
        check("d4_flush_occ", d4_occ, 3'd0);
        check("d4_flush_result", d4_out_result, 32'h0);
        check("d4_flush_carry", d4_out_carry, 1'b0);
        d4_out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("d4_no_ghost_valid", d4_out_valid, 1'b0);
            check("d4_empty_result", d4_out_result, 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_result_pipe.md
Name: alu_result_pipe

Overview:
- Parametrised elastic pipeline for ALU outputs: carry, result and branch flag.
- DEPTH register stages with valid/ready handshake, bubble collapsing, synchronous flush and an occupancy count.
- Sits between the ALU and the writeback/branch-resolve logic.
- Replaces the fixed single-stage ALU output register; allows ALU output retiming and back-pressure from a stalled consumer.

Parameters:
- DATA_W, 32, width of result payload.
- DEPTH, 2, number of register stages (legal range 1..8).
- CLEAR_DATA, 0: if 1, a stage's payload registers are zeroed whenever that stage becomes invalid (flush or drain without refill). If 0, payload holds its last value.

Ports:
- clk_i  input  1  clock, rising edge.
- async_reset_i  input  1  asynchronous active-low reset.
- flush_i  input  1  synchronous flush; discards all in-flight entries.
- in_valid_i  input  1  upstream payload valid.
- in_ready_o  output  1  block can accept payload this cycle.
- in_carry_i  input  1  ALU carry.
- in_result_i  input  DATA_W  ALU result.
- in_branch_i  input  1  ALU branch flag.
- out_valid_o  output  1  output stage holds valid entry.
- out_ready_i  input  1  downstream accepts entry.
- out_carry_o  output  1  carry of output entry.
- out_result_o  output  DATA_W  result of output entry.
- out_branch_o  output  1  branch flag of output entry.
- occupancy_o  output  $clog2(DEPTH+1)  number of valid entries held.

Behaviour:
- Stages 0..DEPTH-1. Stage 0 takes input; stage DEPTH-1 drives outputs. Each stage has valid_k plus payload {carry, result, branch}.
- Readiness chain: rdy_DEPTH = out_ready_i; rdy_k = !valid_k || rdy_{k+1}. in_ready_o = rdy_0 (combinational through chain; no register on ready path).
- Stage k loads from stage k-1 (or input for k=0) when rdy_k is high:
  - valid_k <= valid_{k-1} (or in_valid_i).
  - Payload loads only when the incoming valid is 1.
  - Bubbles collapse: an empty stage always accepts.
- Input transfer: in_valid_i && in_ready_o. Output transfer: out_valid_o && out_ready_i.
- Latency with no back-pressure: DEPTH cycles from input transfer to out_valid_o.
- Throughput: 1 entry/cycle. Capacity: DEPTH entries.
- Stall stability: while out_valid_o=1 and out_ready_i=0, out_* payload and out_valid_o hold unchanged.
- Ordering: strict FIFO order; no entry is dropped or duplicated except by flush.
- occupancy_o is a registered counter:
  - +1 on input transfer, -1 on output transfer, unchanged when both occur.
  - Always equals the popcount of valid_k. Never exceeds DEPTH; never underflows.
- Flush (flush_i=1 at a clock edge) has priority over all other activity:
  - All valid_k <= 0 and occupancy_o <= 0.
  - The same-cycle input beat is discarded. in_ready_o is forced 1 during flush so upstream does not stall.
  - The same-cycle output beat still counts as consumed by downstream; its data is not repeated.
  - With CLEAR_DATA=1, payloads <= 0.
- Full: all stages valid and out_ready_i=0 → in_ready_o=0; input holds.
- Full with out_ready_i=1: in_ready_o=1; a simultaneous in/out transfer keeps occupancy at DEPTH.
- Empty: out_valid_o=0. Output payload is don't-care, or 0 when CLEAR_DATA=1.
- Reset (async_reset_i=0, at any time including mid-transfer): immediately clears all valid_k, payloads, occupancy_o and out_* to 0. After deassertion, first capture occurs on the next rising edge.
- DEPTH=1 degenerates to a single register with handshake: in_ready_o = !valid_0 || out_ready_i.

Decomposition:
- Shared package/header alu_pipe_pkg:
  - ALU_DATA_W = 32.
  - ALU_PIPE_MAX_DEPTH = 8.
  - Payload bit-field layout constants: CARRY_BIT, BRANCH_BIT, RESULT_LSB.
- Sub-module alu_pipe_stage: one valid+payload register with async reset, load enable, flush and CLEAR_DATA. Generated DEPTH times.
- Top level holds the ready chain and the occupancy counter.

Test Plan:
- Reset/defaults: DEPTH=2, assert reset mid-stream with occupancy=2 → all outputs 0 immediately, occupancy_o=0, in_ready_o=1 after release.
- Streaming: out_ready_i=1, send results 0x1,0x2,0x3 with carry=1,0,1 on consecutive cycles → same values at output in order, first at cycle+2, then one per cycle, occupancy_o steady at 2.
- Back-pressure: out_ready_i=0, push 0xA,0xB → in_ready_o=0 after 2 entries, out_result_o holds 0xA stable; raise out_ready_i → 0xA then 0xB, occupancy 2→1→0.
- Bubble collapse: DEPTH=4, single entry 0xDEAD with out_ready_i=0 → reaches output stage after 4 cycles, in_ready_o stays 1, occupancy_o=1.
- Flush: occupancy 2, flush_i=1 with in_valid_i=1 (0x55) → next cycle out_valid_o=0, occupancy_o=0, 0x55 never appears; with CLEAR_DATA=1, out_result_o=0.
- Full simultaneous: DEPTH=2 full, in_valid_i=1, out_ready_i=1 continuously for 10 cycles → occupancy_o constant 2, all 10 inputs emerge in order, branch flags preserved.
